// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: loads a pattern, shifts it out MSB-first with
// optional repeats separated by idle gaps, and signals completion with a DONE pulse.
module seq_pattern_tx #(
  parameter int   WIDTH    = 8,
  parameter int   LEN_W    = 4,
  parameter int   CNT_W    = 4,
  parameter int   GAP      = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] PATTERN,
  input  logic [LEN_W-1:0] LEN,
  input  logic [CNT_W-1:0] REPEAT,
  input  logic             ABORT,
  output logic             X_OUT,
  output logic             X_VALID,
  output logic             BUSY,
  output logic             DONE
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAPW, DONE_S} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pat_q, pat_n;
  logic [IDX_W-1:0] top_q, top_n, idx_q, idx_n;
  logic [CNT_W-1:0] rep_q, rep_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic [LEN_W-1:0] len_eff;
  logic [IDX_W-1:0] top_in;
  logic             x_d, valid_d, busy_d, done_d;

  // Out-of-range or zero length falls back to the full register width.
  always_comb begin
    len_eff = LEN;
    if (LEN == '0 || LEN > LEN_W'(WIDTH)) len_eff = LEN_W'(WIDTH);
    top_in = IDX_W'(len_eff - LEN_W'(1));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      pat_q <= '0;
      top_q <= '0;
      idx_q <= '0;
      rep_q <= '0;
      gap_q <= '0;
    end else begin
      state <= state_n;
      pat_q <= pat_n;
      top_q <= top_n;
      idx_q <= idx_n;
      rep_q <= rep_n;
      gap_q <= gap_n;
    end
  end

  always_comb begin
    state_n = state;
    pat_n   = pat_q;
    top_n   = top_q;
    idx_n   = idx_q;
    rep_n   = rep_q;
    gap_n   = gap_q;
    case (state)
      IDLE: if (START) begin
        state_n = SHIFT;
        pat_n   = PATTERN;
        top_n   = top_in;
        idx_n   = top_in;
        rep_n   = REPEAT;
      end
      SHIFT: begin
        if (idx_q != '0) begin
          idx_n = idx_q - IDX_W'(1);
        end else if (rep_q != '0) begin
          if (GAP > 0) begin
            state_n = GAPW;
            gap_n   = GAP_LAST;
          end else begin
            idx_n = top_q;
            rep_n = rep_q - CNT_W'(1);
          end
        end else begin
          state_n = DONE_S;
        end
      end
      GAPW: begin
        if (gap_q == '0) begin
          state_n = SHIFT;
          idx_n   = top_q;
          rep_n   = rep_q - CNT_W'(1);
        end else begin
          gap_n = gap_q - GAP_W'(1);
        end
      end
      DONE_S:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (ABORT && state != IDLE) begin
      state_n = IDLE;
      pat_n   = '0;
      top_n   = '0;
      idx_n   = '0;
      rep_n   = '0;
      gap_n   = '0;
    end
  end

  // Outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    x_d     = IDLE_LVL;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_n)
      SHIFT: begin
        x_d     = pat_n[idx_n];
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      GAPW:    busy_d = 1'b1;
      DONE_S:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      X_OUT   <= IDLE_LVL;
      X_VALID <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      X_OUT   <= x_d;
      X_VALID <= valid_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: single send, repeats with gaps,
// length edge cases, ignored START, abort and asynchronous reset.
module tb_seq_pattern_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [7:0] PATTERN = '0;
  logic [3:0] LEN = '0;
  logic [3:0] REPEAT = '0;
  logic       X_OUT, X_VALID, BUSY, DONE;
  int         total = 0;
  int         bad = 0;

  always #5 CLK = ~CLK;

  seq_pattern_tx #(.WIDTH(8), .LEN_W(4), .CNT_W(4), .GAP(2), .IDLE_LVL(1'b0)) dut (
    .CLK(CLK), .RST(RST), .START(START), .PATTERN(PATTERN), .LEN(LEN),
    .REPEAT(REPEAT), .ABORT(ABORT), .X_OUT(X_OUT), .X_VALID(X_VALID),
    .BUSY(BUSY), .DONE(DONE)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Launch a transfer, then scramble the inputs to prove only latched copies matter.
  task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    PATTERN = p;
    LEN     = l;
    REPEAT  = r;
    START   = 1'b1;
    tick;
    START   = 1'b0;
    PATTERN = 8'h00;
    LEN     = 4'd2;
    REPEAT  = 4'd7;
  endtask

  task automatic expect_stream(input string tag, input int n,
                               input logic [31:0] xs, input logic [31:0] vs);
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick;
      chk($sformatf("%s.x%0d", tag, i + 1), X_OUT, xs[n-1-i]);
      chk($sformatf("%s.v%0d", tag, i + 1), X_VALID, vs[n-1-i]);
      chk($sformatf("%s.busy%0d", tag, i + 1), BUSY, 1);
      chk($sformatf("%s.done%0d", tag, i + 1), DONE, 0);
    end
    tick;
    chk({tag, ".done"}, DONE, 1);
    chk({tag, ".done_busy"}, BUSY, 0);
    chk({tag, ".done_v"}, X_VALID, 0);
    chk({tag, ".done_x"}, X_OUT, 0);
    tick;
    chk({tag, ".idle_done"}, DONE, 0);
    chk({tag, ".idle_busy"}, BUSY, 0);
  endtask

  initial begin
    #12;
    chk("rst.x", X_OUT, 0);
    chk("rst.v", X_VALID, 0);
    chk("rst.busy", BUSY, 0);
    chk("rst.done", DONE, 0);
    RST = 1'b0;
    tick;

    // Upper pattern bits must be ignored when LEN=4.
    send(8'hFB, 4'd4, 4'd0);
    expect_stream("single", 4, 32'b1011, 32'b1111);

    send(8'h0B, 4'd4, 4'd2);
    expect_stream("gap", 16, 32'b1011001011001011, 32'b1111001111001111);

    send(8'hA5, 4'd0, 4'd0);
    expect_stream("len0", 8, 32'b10100101, 32'b11111111);

    send(8'hA5, 4'd15, 4'd0);
    expect_stream("len15", 8, 32'b10100101, 32'b11111111);

    // START during SHIFT is ignored; ABORT drops to idle without DONE.
    send(8'hA5, 4'd8, 4'd0);
    chk("abort.x1", X_OUT, 1);
    tick;
    chk("abort.x2", X_OUT, 0);
    START   = 1'b1;
    PATTERN = 8'hFF;
    tick;
    START = 1'b0;
    chk("abort.x3", X_OUT, 1);
    chk("abort.v3", X_VALID, 1);
    ABORT = 1'b1;
    tick;
    ABORT = 1'b0;
    chk("abort.v4", X_VALID, 0);
    chk("abort.busy4", BUSY, 0);
    chk("abort.x4", X_OUT, 0);
    chk("abort.done4", DONE, 0);
    tick;
    chk("abort.done5", DONE, 0);
    chk("abort.busy5", BUSY, 0);
    send(8'h0B, 4'd4, 4'd0);
    expect_stream("post_abort", 4, 32'b1011, 32'b1111);

    // Asynchronous reset in the middle of a cycle, mid-transfer.
    send(8'hFF, 4'd8, 4'd3);
    tick;
    #3 RST = 1'b1;
    #1;
    chk("arst.x", X_OUT, 0);
    chk("arst.v", X_VALID, 0);
    chk("arst.busy", BUSY, 0);
    chk("arst.done", DONE, 0);
    tick;
    RST = 1'b0;
    tick;
    chk("arst.after_done", DONE, 0);
    chk("arst.after_busy", BUSY, 0);
    send(8'h0B, 4'd4, 4'd0);
    expect_stream("post_rst", 4, 32'b1011, 32'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter. Drives the single-bit X stream that our serial sequence-detector FSMs consume, replacing hand-timed stimulus with a programmable source.
- Parallel-loads a bit pattern, shifts it out MSB-first one bit per clock, and optionally repeats it with idle gaps between repetitions.
- Uses a START/BUSY/DONE handshake toward the controlling logic.

Parameters:
- WIDTH, 8, pattern register width in bits.
- LEN_W, 4, width of LEN; must satisfy 2^LEN_W > WIDTH.
- CNT_W, 4, width of REPEAT.
- GAP, 2, idle cycles inserted between repetitions; 0 means back-to-back repetitions.
- IDLE_LVL, 1'b0, X_OUT level whenever no pattern bit is driven.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request to transmit; sampled only in IDLE.
- PATTERN  in  WIDTH  bits to send; active field is PATTERN[LEN-1:0].
- LEN  in  LEN_W  number of bits per repetition.
- REPEAT  in  CNT_W  extra repetitions; total transmissions = REPEAT+1.
- ABORT  in  1  synchronous cancel of the current transfer.
- X_OUT  out  1  serial data out.
- X_VALID  out  1  high when X_OUT carries a pattern bit.
- BUSY  out  1  high from the first bit through the last bit/gap of a transfer.
- DONE  out  1  one-cycle pulse after the final bit.

Behaviour:
- One clock domain. Reset is asynchronous and active-high; all flops clear immediately when RST=1, independent of CLK.
- Reset values: X_OUT=IDLE_LVL, X_VALID=0, BUSY=0, DONE=0, state=IDLE, all counters 0.
- States: IDLE, SHIFT, GAPW, DONE_S. All outputs are registered.
- IDLE:
  - START=1 at an edge latches PATTERN, the effective length, and REPEAT, then moves to SHIFT.
  - The first bit appears the cycle after START is sampled (latency 1).
- Effective length: LEN=0 or LEN>WIDTH is treated as WIDTH.
- SHIFT:
  - X_OUT = latched pattern bit [len-1-i] in cycle i; X_VALID=1, BUSY=1.
  - After bit 0 is driven:
    - remaining repeats >0 and GAP>0: go to GAPW.
    - remaining repeats >0 and GAP=0: reload the bit index and continue SHIFT with no idle cycle.
    - remaining repeats =0: go to DONE_S.
- GAPW: exactly GAP cycles with X_OUT=IDLE_LVL, X_VALID=0, BUSY=1. Then decrement the repeat counter and return to SHIFT at bit len-1.
- DONE_S: lasts one cycle with DONE=1, BUSY=0, X_VALID=0, X_OUT=IDLE_LVL, then returns to IDLE.
- START handling:
  - START is ignored in SHIFT, GAPW and DONE_S; it is not queued.
  - Inputs changing during a transfer have no effect; only the latched copies are used.
- ABORT:
  - ABORT=1 at an edge in any non-IDLE state forces IDLE on the next cycle with outputs at reset values. No DONE pulse is produced.
  - ABORT has priority over START. ABORT in IDLE has no effect.
- Reset mid-transfer: the transfer is discarded immediately and no DONE pulse is produced. The next START after RST falls starts a fresh transfer.
- Transfer length in cycles: (REPEAT+1)*len + REPEAT*GAP. DONE follows in the next cycle.

Test Plan:
- Reset: RST=1 asynchronously mid-cycle → X_OUT=0, X_VALID=0, BUSY=0, DONE=0 immediately, without a clock edge.
- Single send, PATTERN=8'h0B, LEN=4, REPEAT=0, START pulsed at edge 0 → X_OUT=1,0,1,1 with X_VALID=1 on cycles 1–4; DONE=1 and BUSY=0 on cycle 5; IDLE on cycle 6.
- Repeat with gap, same pattern, REPEAT=2, GAP=2 → stream 1011 00 1011 00 1011 on cycles 1–16, with X_VALID low only during the 00 gaps; DONE on cycle 17.
- Length edge cases: LEN=0 with PATTERN=8'hA5 → 10100101 on cycles 1–8, DONE on cycle 9. LEN=15 → same as WIDTH.
- Busy and abort: START re-pulsed at cycle 2 → ignored, output unchanged. ABORT at cycle 3 → cycle 4 is IDLE with X_VALID=0 and no DONE pulse; a new START is accepted afterwards.
- Loopback: connect X_OUT to the detector's X_IN with a pattern containing the target sequence → detector Y_OUT asserts on the expected cycle.
